// File: rtl/lsu_data_memory.sv
// Data memory behind a RISC-V load/store front end: byte/half/word access with
// sign/zero extension, programmable wait states and fault reporting.
module lsu_data_memory #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 4096,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [2:0]        i_req_funct3,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_rsp_valid,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_fault,
  output logic [1:0]        dbg_state
);

  // Handshake: a request is accepted on a rising edge where i_req_valid and
  // o_req_ready are both high; o_req_ready is a function of state only. The
  // response is a single-cycle o_rsp_valid strobe with no backpressure.

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [2:0] WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        wait_cnt_q, wait_cnt_d;
  logic [31:0]       mem [DEPTH_WORDS];
  logic [31:0]       rd_word_q;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [1:0]        lane_q;
  logic [IDX_W-1:0]  idx_q;
  logic              fault_q;

  logic              accept;
  logic [IDX_W-1:0]  req_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic [1:0]        req_lane;
  logic              req_illegal;
  logic              req_misalign;
  logic              req_oor;
  logic              req_fault;
  logic [3:0]        req_be;
  logic [31:0]       req_wlanes;

  assign accept   = i_req_valid && (state_q == S_IDLE);
  assign req_idx  = i_req_addr[IDX_W+1:2];
  assign req_lane = i_req_addr[1:0];

  always_comb begin
    req_illegal  = i_req_we ? (i_req_funct3 > 3'd2)
                            : (i_req_funct3 == 3'd3 || i_req_funct3 == 3'd6 || i_req_funct3 == 3'd7);
    req_misalign = ((i_req_funct3[1:0] == 2'd1) && req_lane[0]) ||
                   ((i_req_funct3[1:0] == 2'd2) && (req_lane != 2'd0));
    req_oor      = (i_req_addr >> (IDX_W + 2)) != '0;
    req_fault    = req_illegal || req_misalign || req_oor;
    case (i_req_funct3[1:0])
      2'd0: begin
        req_be     = 4'b0001 << req_lane;
        req_wlanes = {4{i_req_wdata[7:0]}};
      end
      2'd1: begin
        req_be     = req_lane[1] ? 4'b1100 : 4'b0011;
        req_wlanes = {2{i_req_wdata[15:0]}};
      end
      default: begin
        req_be     = 4'b1111;
        req_wlanes = i_req_wdata;
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (i_req_valid) begin
          state_d    = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
          wait_cnt_d = WAIT_LOAD;
        end
      end
      S_WAIT: begin
        if (wait_cnt_q == 3'd0) state_d = S_RESP;
        else                    wait_cnt_d = wait_cnt_q - 3'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= 3'd0;
      we_q       <= 1'b0;
      f3_q       <= 3'd0;
      lane_q     <= 2'd0;
      idx_q      <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (accept) begin
        we_q    <= i_req_we;
        f3_q    <= i_req_funct3;
        lane_q  <= req_lane;
        idx_q   <= req_idx;
        fault_q <= req_fault;
      end
    end
  end

  // With zero wait states the RESP-entry edge is the accept edge itself, so the
  // read index comes straight from the request rather than the capture register.
  assign rd_idx = (state_q == S_IDLE) ? req_idx : idx_q;

  always_ff @(posedge clk) begin
    if (accept && i_req_we && !req_fault) begin
      for (int b = 0; b < 4; b++) begin
        if (req_be[b]) mem[req_idx][8*b +: 8] <= req_wlanes[8*b +: 8];
      end
    end
    if (state_d == S_RESP && state_q != S_RESP) rd_word_q <= mem[rd_idx];
  end

  logic [31:0] rd_shift;
  logic [15:0] rd_half;
  logic [31:0] rd_ext;

  always_comb begin
    rd_shift = rd_word_q >> {lane_q, 3'b000};
    rd_half  = lane_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];
    case (f3_q)
      3'b000:  rd_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
      3'b010:  rd_ext = rd_word_q;
      3'b100:  rd_ext = {24'd0, rd_shift[7:0]};
      3'b101:  rd_ext = {16'd0, rd_half};
      default: rd_ext = 32'd0;
    endcase
  end

  assign o_req_ready = (state_q == S_IDLE);
  assign o_rsp_valid = (state_q == S_RESP);
  assign o_rsp_fault = (state_q == S_RESP) && fault_q;
  assign o_rsp_rdata = ((state_q == S_RESP) && !we_q && !fault_q) ? rd_ext : 32'd0;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_lsu_data_memory.sv
// Bench for lsu_data_memory: three instances (0, 3 and 2 wait states) checked
// against a byte-array reference model of the load/store rules.
module tb_lsu_data_memory;

  logic        clk;
  logic        rst_n     [3];
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_we    [3];
  logic [2:0]  req_f3    [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic        rsp_valid [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_fault [3];
  logic [1:0]  dbg       [3];

  int ws_of [3] = '{0, 3, 2};
  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] ref_mem [3][0:1023];

  int last_lat;
  int last_ready_low;
  logic last_after;

  lsu_data_memory #(.WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
    .i_req_we(req_we[0]), .i_req_funct3(req_f3[0]), .i_req_addr(req_addr[0]),
    .i_req_wdata(req_wdata[0]), .o_rsp_valid(rsp_valid[0]), .o_rsp_rdata(rsp_rdata[0]),
    .o_rsp_fault(rsp_fault[0]), .dbg_state(dbg[0]));

  lsu_data_memory #(.WAIT_STATES(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
    .i_req_we(req_we[1]), .i_req_funct3(req_f3[1]), .i_req_addr(req_addr[1]),
    .i_req_wdata(req_wdata[1]), .o_rsp_valid(rsp_valid[1]), .o_rsp_rdata(rsp_rdata[1]),
    .o_rsp_fault(rsp_fault[1]), .dbg_state(dbg[1]));

  lsu_data_memory #(.WAIT_STATES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n[2]), .i_req_valid(req_valid[2]), .o_req_ready(req_ready[2]),
    .i_req_we(req_we[2]), .i_req_funct3(req_f3[2]), .i_req_addr(req_addr[2]),
    .i_req_wdata(req_wdata[2]), .o_rsp_valid(rsp_valid[2]), .o_rsp_rdata(rsp_rdata[2]),
    .o_rsp_fault(rsp_fault[2]), .dbg_state(dbg[2]));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: applies a request to the byte array, returns the response.
  task automatic model_access(input int d, input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wd,
                              output logic [31:0] exp_rd, output logic exp_fault);
    int size;
    logic legal;
    logic [31:0] val;
    size   = 1 << f3[1:0];
    legal  = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    exp_fault = !legal || (addr % size != 0) || (addr >= 32'd4 * 32'd4096);
    exp_rd = 32'd0;
    if (exp_fault) return;
    if (we) begin
      for (int i = 0; i < size; i++) ref_mem[d][addr + i] = 8'((wd >> (8 * i)) & 32'hFF);
    end else begin
      val = 32'd0;
      for (int i = 0; i < size; i++) val = val + (32'(ref_mem[d][addr + i]) << (8 * i));
      if (!f3[2] && size < 4 && val[8*size-1]) val = val | ~((32'd1 << (8 * size)) - 32'd1);
      exp_rd = val;
    end
  endtask

  // driver: one request, waits for its response (bounded)
  task automatic do_req(input int d, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rdata, output logic fault);
    bit acc;
    rdata = 32'd0; fault = 1'b0; last_lat = 0; last_ready_low = 0; last_after = 1'b0;
    req_we[d] = we; req_f3[d] = f3; req_addr[d] = addr; req_wdata[d] = wd; req_valid[d] = 1'b1;
    acc = 1'b0;
    for (int n = 0; n < 50 && !acc; n++) begin
      acc = req_ready[d];
      @(posedge clk); #1;
    end
    req_valid[d] = 1'b0;
    req_we[d] = 1'($urandom); req_f3[d] = 3'($urandom); req_addr[d] = $urandom; req_wdata[d] = $urandom;
    if (!acc) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout dut%0d addr=%h: no accept within 50 cycles", d, addr);
      return;
    end
    for (int n = 1; n <= 20; n++) begin
      if (!req_ready[d]) last_ready_low++;
      if (rsp_valid[d]) begin
        last_lat = n; rdata = rsp_rdata[d]; fault = rsp_fault[d];
        break;
      end
      @(posedge clk); #1;
    end
    if (last_lat == 0) begin
      n_checks++; n_fail++;
      $display("FAIL rsp_timeout dut%0d addr=%h: no response within 20 cycles", d, addr);
      return;
    end
    @(posedge clk); #1;
    last_after = rsp_valid[d];
  endtask

  task automatic test_reset;
    for (int d = 0; d < 3; d++) begin
      n_checks++; if (req_ready[d] !== 1'b1) begin n_fail++; $display("FAIL reset_ready dut%0d got=%b exp=1", d, req_ready[d]); end
      n_checks++; if (rsp_valid[d] !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid dut%0d got=%b exp=0", d, rsp_valid[d]); end
      n_checks++; if (rsp_rdata[d] !== 32'd0) begin n_fail++; $display("FAIL reset_rdata dut%0d got=%h exp=0", d, rsp_rdata[d]); end
      n_checks++; if (rsp_fault[d] !== 1'b0) begin n_fail++; $display("FAIL reset_fault dut%0d got=%b exp=0", d, rsp_fault[d]); end
    end
  endtask

  task automatic test_basic;
    logic [31:0] rd; logic f; logic [31:0] e; logic ef;
    model_access(0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, e, ef);
    do_req(0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, rd, f);
    n_checks++; if (f !== 1'b0 || rd !== 32'd0) begin n_fail++; $display("FAIL sw_rsp got rd=%h f=%b exp rd=0 f=0", rd, f); end
    n_checks++; if (last_ready_low !== 1) begin n_fail++; $display("FAIL sw_ready_low got=%0d exp=1", last_ready_low); end
    do_req(0, 1'b0, 3'd2, 32'h10, 32'h0, rd, f);
    n_checks++; if (rd !== 32'hDEADBEEF || f !== 1'b0) begin n_fail++; $display("FAIL lw_basic got rd=%h f=%b exp rd=deadbeef f=0", rd, f); end
    n_checks++; if (last_lat !== 1) begin n_fail++; $display("FAIL lw_latency_ws0 got=%0d exp=1", last_lat); end
    n_checks++; if (last_after !== 1'b0) begin n_fail++; $display("FAIL rsp_strobe_ws0 got=%b exp=0", last_after); end
  endtask

  task automatic test_subword;
    logic [31:0] rd; logic f; logic [31:0] e; logic ef;
    logic [31:0] addr_t [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
    logic [2:0]  f3_t   [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
    logic [31:0] exp_t  [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
    for (int i = 0; i < 4; i++) begin
      do_req(0, 1'b0, f3_t[i], addr_t[i], 32'h0, rd, f);
      n_checks++;
      if (rd !== exp_t[i] || f !== 1'b0) begin
        n_fail++; $display("FAIL subword_load%0d f3=%0d addr=%h got rd=%h f=%b exp rd=%h f=0", i, f3_t[i], addr_t[i], rd, f, exp_t[i]);
      end
    end
    model_access(0, 1'b1, 3'd0, 32'h11, 32'h55, e, ef);
    do_req(0, 1'b1, 3'd0, 32'h11, 32'h55, rd, f);
    do_req(0, 1'b0, 3'd2, 32'h10, 32'h0, rd, f);
    n_checks++; if (rd !== 32'hDEAD55EF) begin n_fail++; $display("FAIL sb_merge got=%h exp=dead55ef", rd); end
  endtask

  task automatic test_faults;
    logic [31:0] rd; logic f; logic [31:0] e; logic ef;
    do_req(0, 1'b0, 3'd2, 32'h12, 32'h0, rd, f);
    n_checks++; if (f !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL lw_misalign got rd=%h f=%b exp rd=0 f=1", rd, f); end
    model_access(0, 1'b1, 3'd2, 32'h20, 32'h12345678, e, ef);
    do_req(0, 1'b1, 3'd2, 32'h20, 32'h12345678, rd, f);
    do_req(0, 1'b1, 3'd1, 32'h21, 32'hAAAA, rd, f);
    n_checks++; if (f !== 1'b1) begin n_fail++; $display("FAIL sh_misalign got f=%b exp=1", f); end
    do_req(0, 1'b0, 3'd2, 32'h20, 32'h0, rd, f);
    n_checks++; if (rd !== 32'h12345678) begin n_fail++; $display("FAIL sh_fault_nowrite got=%h exp=12345678", rd); end
    do_req(0, 1'b0, 3'd3, 32'h20, 32'h0, rd, f);
    n_checks++; if (f !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL illegal_f3 got rd=%h f=%b exp rd=0 f=1", rd, f); end
    do_req(0, 1'b0, 3'd2, 32'h4000, 32'h0, rd, f);
    n_checks++; if (f !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL out_of_range got rd=%h f=%b exp rd=0 f=1", rd, f); end
  endtask

  task automatic test_wait;
    logic [31:0] rd; logic f; logic [31:0] e; logic ef; logic [31:0] v;
    v = $urandom;
    model_access(1, 1'b1, 3'd2, 32'h40, v, e, ef);
    do_req(1, 1'b1, 3'd2, 32'h40, v, rd, f);
    do_req(1, 1'b0, 3'd2, 32'h40, 32'h0, rd, f);
    n_checks++; if (rd !== v) begin n_fail++; $display("FAIL lw_ws3_data got=%h exp=%h", rd, v); end
    n_checks++; if (last_lat !== 4) begin n_fail++; $display("FAIL lw_ws3_latency got=%0d exp=4", last_lat); end
    n_checks++; if (last_ready_low !== 4) begin n_fail++; $display("FAIL lw_ws3_ready_low got=%0d exp=4", last_ready_low); end
    n_checks++; if (last_after !== 1'b0) begin n_fail++; $display("FAIL rsp_strobe_ws3 got=%b exp=0", last_after); end
  endtask

  task automatic test_back_to_back;
    int acc_q[$];
    int rsp_cnt;
    rsp_cnt = 0;
    req_we[1] = 1'b0; req_f3[1] = 3'd2; req_addr[1] = 32'h40; req_valid[1] = 1'b1;
    for (int n = 0; n < 16; n++) begin
      if (req_ready[1]) acc_q.push_back(n);
      if (rsp_valid[1]) rsp_cnt++;
      @(posedge clk); #1;
    end
    req_valid[1] = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    n_checks++; if (acc_q.size() != 4) begin n_fail++; $display("FAIL b2b_accept_count got=%0d exp=4", acc_q.size()); end
    for (int i = 1; i < acc_q.size(); i++) begin
      n_checks++;
      if (acc_q[i] - acc_q[i-1] != 5) begin n_fail++; $display("FAIL b2b_gap%0d got=%0d exp=5", i, acc_q[i] - acc_q[i-1]); end
    end
    n_checks++; if (rsp_cnt != 3) begin n_fail++; $display("FAIL b2b_rsp_count got=%0d exp=3", rsp_cnt); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; logic f; logic [31:0] e; logic ef; logic [31:0] v; int seen;
    v = $urandom;
    model_access(2, 1'b1, 3'd2, 32'h30, v, e, ef);
    req_we[2] = 1'b1; req_f3[2] = 3'd2; req_addr[2] = 32'h30; req_wdata[2] = v; req_valid[2] = 1'b1;
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    rst_n[2] = 1'b0;
    seen = 0;
    for (int n = 0; n < 5; n++) begin
      if (rsp_valid[2]) seen++;
      @(posedge clk); #1;
    end
    @(negedge clk); rst_n[2] = 1'b1;
    @(posedge clk); #1;
    for (int n = 0; n < 4; n++) begin
      if (rsp_valid[2]) seen++;
      @(posedge clk); #1;
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL reset_mid_rsp got=%0d strobes exp=0", seen); end
    n_checks++; if (req_ready[2] !== 1'b1) begin n_fail++; $display("FAIL reset_mid_ready got=%b exp=1", req_ready[2]); end
    do_req(2, 1'b0, 3'd2, 32'h30, 32'h0, rd, f);
    n_checks++; if (rd !== v || f !== 1'b0) begin n_fail++; $display("FAIL reset_mid_store_kept got=%h f=%b exp=%h f=0", rd, f, v); end
  endtask

  task automatic test_random;
    logic [31:0] rd; logic f; logic [31:0] e; logic ef;
    logic we; logic [2:0] f3; logic [31:0] addr; logic [31:0] wd;
    for (int d = 0; d < 3; d++) begin
      for (int w = 0; w < 16; w++) begin
        wd = $urandom;
        model_access(d, 1'b1, 3'd2, 32'h100 + 32'(4 * w), wd, e, ef);
        do_req(d, 1'b1, 3'd2, 32'h100 + 32'(4 * w), wd, rd, f);
      end
      for (int i = 0; i < 60; i++) begin
        we   = 1'($urandom);
        f3   = 3'($urandom_range(0, 7));
        addr = ($urandom_range(0, 9) == 0) ? 32'h4000 + $urandom_range(0, 255)
                                           : 32'h100 + $urandom_range(0, 63);
        wd   = $urandom;
        model_access(d, we, f3, addr, wd, e, ef);
        do_req(d, we, f3, addr, wd, rd, f);
        n_checks++;
        if (rd !== e || f !== ef) begin
          n_fail++;
          $display("FAIL rand dut%0d op%0d we=%b f3=%0d addr=%h got rd=%h f=%b exp rd=%h f=%b", d, i, we, f3, addr, rd, f, e, ef);
        end
        n_checks++;
        if (last_lat != ws_of[d] + 1) begin
          n_fail++; $display("FAIL rand_latency dut%0d op%0d got=%0d exp=%0d", d, i, last_lat, ws_of[d] + 1);
        end
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst_n[d] = 1'b0; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_f3[d] = 3'd0;
      req_addr[d] = 32'd0; req_wdata[d] = 32'd0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;
    @(posedge clk); #1;
    test_reset;
    test_basic;
    test_subword;
    test_faults;
    test_wait;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
